// File: rtl/tt_um_bcd_display_shivam.sv
// Binary-to-BCD/hex display back end: double-dabble converter feeding a 3-digit multiplexed 7-segment scanner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of decimal digits 2 and 1.
module tt_um_bcd_display_shivam #(
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_bin, r_cap, w_bin_nxt;
  logic [11:0]   r_bcd, w_adj, w_bcd_nxt;
  logic [2:0]    r_cnt;
  logic          r_mode, r_strobe;
  // Digit register layout: [5] decimal point, [4] blank, [3:0] digit code
  logic [5:0]    r_d2, r_d1, r_d0, w_d2, w_d1, w_d0, w_dsel;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [7:0]    r_seg, w_seg;
  logic [2:0]    r_en, w_en;
  logic          w_hold, w_blank2, w_blank1, w_unused;

  assign w_hold   = uio_in[7];
  assign w_unused = &{1'b0, uio_in[6:1]};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    seg7 = '0;
    case (d)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  4'hF: seg7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_IDLE;
    else if (ena) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_hold) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_cnt == 3'd7) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_nxt = {w_adj[10:0], r_bin[7]};
    w_bin_nxt = {r_bin[6:0], 1'b0};
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank2 = (r_bcd[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_bcd[7:4] == 4'd0);
`else
  assign w_blank2 = 1'b0;
  assign w_blank1 = 1'b0;
`endif

  assign w_d2 = r_mode ? {2'b00, r_cap[7:4]} : {1'b0, w_blank2, r_bcd[11:8]};
  assign w_d1 = r_mode ? {2'b00, r_cap[3:0]} : {1'b0, w_blank1, r_bcd[7:4]};
  assign w_d0 = r_mode ? 6'b110000            : {2'b00, r_bcd[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= '0;
      r_cap    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      r_d2     <= '0;
      r_d1     <= '0;
      r_d0     <= '0;
      r_strobe <= 1'b0;
    end else if (ena) begin
      r_strobe <= (r_state == S_UPDATE);
      case (r_state)
        S_IDLE: if (!w_hold) begin
          r_bin  <= ui_in;
          r_cap  <= ui_in;
          r_mode <= uio_in[0];
          r_bcd  <= '0;
          r_cnt  <= '0;
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt + 3'd1;
        end
        S_UPDATE: begin
          r_d2 <= w_d2;
          r_d1 <= w_d1;
          r_d0 <= w_d0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dsel = r_d0;
    w_en   = 3'b001;
    case (r_idx)
      2'd1:    begin w_dsel = r_d1; w_en = 3'b010; end
      2'd2:    begin w_dsel = r_d2; w_en = 3'b100; end
      default: ;
    endcase
    w_seg = {w_dsel[5], w_dsel[4] ? 7'h00 : seg7(w_dsel[3:0])};
  end

  // Segments and enables are registered together so they switch on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= 8'h3F;
      r_en  <= 3'b001;
    end else if (ena) begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      r_seg <= w_seg;
      r_en  <= w_en;
    end
  end

  assign uo_out  = r_seg;
  assign uio_out = {4'b0000, r_strobe, r_en};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_bcd_display_shivam.sv
// Self-checking bench for tt_um_bcd_display_shivam: scoreboard of expected displays per capture, checked on strobe.
module tb_tt_um_bcd_display_shivam;
  localparam int unsigned DIV = 4;
  typedef logic [23:0] disp_t;  // {digit2, digit1, digit0} segment bytes

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_bcd_display_shivam #(.REFRESH_DIV(DIV)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  disp_t       sb[$];
  disp_t       cur_exp = {3{8'h3F}};
  int unsigned m_cnt = 0;
  bit          m_str_due = 1'b0;
  int          n_strobe = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam disp_t D_000 = {8'h00, 8'h00, 8'h3F};
  localparam disp_t D_042 = {8'h00, 8'h66, 8'h5B};
  localparam disp_t D_099 = {8'h00, 8'h6F, 8'h6F};
`else
  localparam disp_t D_000 = {8'h3F, 8'h3F, 8'h3F};
  localparam disp_t D_042 = {8'h3F, 8'h66, 8'h5B};
  localparam disp_t D_099 = {8'h3F, 8'h6F, 8'h6F};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] tbl [16];
    tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    return tbl[d];
  endfunction

  function automatic disp_t expect_disp(input logic [7:0] v, input logic hex);
    logic [7:0] s2, s1, s0;
    if (hex) begin
      s2 = seg_of(v[7:4]); s1 = seg_of(v[3:0]); s0 = 8'h80;
    end else begin
      s2 = seg_of(4'(v / 100)); s1 = seg_of(4'((v / 10) % 10)); s0 = seg_of(4'(v % 10));
`ifdef LEADING_ZERO_BLANK_EN
      if (v < 100) s2 = 8'h00;
      if (v < 10)  s1 = 8'h00;
`endif
    end
    return {s2, s1, s0};
  endfunction

  // Timing model: capture -> 8 shifts -> update, 10 cycles per conversion
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_str_due = 1'b0; sb.delete();
    end else if (ena) begin
      m_str_due = (m_cnt == 9);
      if (m_cnt == 0) begin
        if (!uio_in[7]) begin
          sb.push_back(expect_disp(ui_in, uio_in[0]));
          m_cnt = 1;
        end
      end else if (m_cnt == 9) m_cnt = 0;
      else m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) cur_exp = {3{8'h3F}};
    else begin
      int unsigned k;
      k = uio_out[1] ? 1 : (uio_out[2] ? 2 : 0);
      chk("strobe", uio_out[3], m_str_due);
      chk("en_onehot", $onehot(uio_out[2:0]), 1);
      chk("seg_scan", uo_out, cur_exp[8*k +: 8]);
      chk("uio_hi", uio_out[7:4], 0);
      if (uio_out[3]) begin
        n_strobe++;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) cur_exp = sb.pop_front();
      end
    end
  end

  task automatic wait_cnt(input int unsigned v);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_cnt == v) break;
    end
    chk("wait_cnt", m_cnt, v);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (uio_out[3]) break;
    end
  endtask

  task automatic read_digit(input int k, output logic [7:0] v);
    for (int i = 0; i < 3 * DIV + 4; i++) begin
      @(negedge clk);
      if (uio_out[k]) break;
    end
    chk("digit_found", uio_out[k], 1);
    v = uo_out;
  endtask

  task automatic chk_display(input string tag, input disp_t exp);
    logic [7:0] v;
    for (int k = 0; k < 3; k++) begin
      read_digit(k, v);
      chk(tag, v, exp[8*k +: 8]);
    end
  endtask

  task automatic chk_visible(input string tag, input disp_t exp);
    int unsigned k;
    k = uio_out[1] ? 1 : (uio_out[2] ? 2 : 0);
    chk(tag, uo_out, exp[8*k +: 8]);
  endtask

  initial begin
    int n, s0;
    logic [7:0] e0, g0;
    repeat (3) @(negedge clk);
    chk("rst_uo", uo_out, 8'h3F);
    chk("rst_uio", uio_out, 8'h01);
    chk("rst_oe", uio_oe, 8'h0F);

    rst_n = 1'b1;
    wait_strobe(n);
    chk("latency", n, 10);
    repeat (2) @(negedge clk);
    chk_display("disp_000", D_000);

    ui_in = 8'd255;
    repeat (25) @(negedge clk);
    chk_display("disp_255", {8'h5B, 8'h6D, 8'h6D});

    uio_in[0] = 1'b1; ui_in = 8'hA7;
    repeat (25) @(negedge clk);
    chk_display("disp_hexA7", {8'h77, 8'h07, 8'h80});

    uio_in[0] = 1'b0; ui_in = 8'd42;
    repeat (12) @(negedge clk);
    wait_cnt(3);
    ui_in = 8'd99;
    wait_strobe(n);
    chk("strobe_042", uio_out[3], 1);
    repeat (2) @(negedge clk);
    chk_visible("vis_042", D_042);
    wait_strobe(n);
    chk("strobe_099", uio_out[3], 1);
    repeat (2) @(negedge clk);
    chk_visible("vis_099", D_099);

    wait_cnt(4);
    uio_in[7] = 1'b1;
    s0 = n_strobe;
    repeat (50) @(negedge clk);
    chk("hold_strobes", n_strobe - s0, 1);
    chk_display("disp_hold", D_099);
    uio_in[7] = 1'b0;

    wait_cnt(3);
    ena = 1'b0;
    e0 = uio_out; g0 = uo_out; s0 = n_strobe;
    repeat (12) @(negedge clk);
    chk("ena_en", uio_out, e0);
    chk("ena_seg", uo_out, g0);
    chk("ena_strobes", n_strobe - s0, 0);
    ena = 1'b1;

    ui_in = 8'd200;
    repeat (12) @(negedge clk);
    wait_cnt(4);
    s0 = n_strobe;
    rst_n = 1'b0;
    #1;
    chk("midrst_uo", uo_out, 8'h3F);
    chk("midrst_uio", uio_out, 8'h01);
    repeat (6) @(negedge clk);
    chk("midrst_strobes", n_strobe - s0, 0);
    chk("midrst_uio2", uio_out, 8'h01);
    rst_n = 1'b1;
    wait_strobe(n);
    chk("latency_200", n, 10);
    repeat (2) @(negedge clk);
    chk_display("disp_200", {8'h5B, 8'h3F, 8'h3F});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tt_um_bcd_display_shivam.md
# tt_um_bcd_display_shivam

Display back end for the 8-bit up/down counter tile: it takes the binary count presented on `ui_in` and decodes it for a multiplexed 3-digit common-cathode 7-segment display. The count is converted by an iterative shift-and-add-3 (double-dabble) state machine, latched into digit registers, and scanned one digit at a time by a refresh prescaler. The block is a standalone TinyTapeout user tile wired to the counter tile's `uo_out`.

## Interface
- `REFRESH_DIV`, default 1024: clock cycles each digit stays enabled; legal range 2..65536.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: tile enable; while low, the FSM and prescaler stall and all outputs hold.
- `ui_in` input 8: binary value to display, unsigned 0..255.
- `uio_in` input 8: bit 0 selects the mode (0 = decimal, 1 = hex); bit 7 is hold (freezes the display). Other bits are ignored.
- `uo_out` output 8: bits [6:0] are segments gfedcba, active-high; bit 7 is the decimal point.
- `uio_out` output 8: bits [2:0] are one-hot digit enables, active-high (bit 0 = ones, bit 1 = tens/low nibble, bit 2 = hundreds/high nibble); bit 3 is the update strobe; bits [7:4] = 0.
- `uio_oe` output 8: constant 8'h0F.

## Operation
- FSM states:
  - IDLE: if hold = 0, capture `ui_in` into the shift register and `uio_in[0]` into mode, clear the BCD accumulator and the bit counter, and go to SHIFT. If hold = 1, stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift the {BCD, bin} register left by one. Exactly 8 cycles, then go to UPDATE.
  - UPDATE: copy the results to the digit registers d2/d1/d0, pulse the strobe, and go to IDLE.
- Decimal mode: d2 = hundreds (0..2), d1 = tens, d0 = ones.
- Hex mode: the SHIFT state still runs, but at UPDATE d2 = `ui_in`[7:4] and d1 = `ui_in`[3:0], both from the captured value, and d0 = blank. The decimal point is lit on digit 0.
- Conversions repeat back-to-back while hold = 0. A change in `ui_in` or mode during SHIFT has no effect until the next capture.
- Hold asserted mid-conversion: the current conversion completes and updates the display; the next capture is blocked.
- Segment decode covers 0-9 and A-F: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71. Blank = 00.
- Scan: the prescaler counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→0. `uio_out[2:0]` is the one-hot of the index; `uo_out` carries the segments of the indexed digit.

## Timing
- Reset values:
  - FSM = IDLE; digit registers = 0; mode = decimal; prescaler = 0; digit index = 0.
  - `uo_out` = 8'h3F; `uio_out` = 8'h01; `uio_oe` = 8'h0F.
- Latency:
  - `ui_in` is sampled at cycle N.
  - Shifts run on cycles N+1..N+8.
  - UPDATE is at N+9. The digit registers and strobe are visible from N+10.
  - Conversion period is 10 cycles.
- The strobe `uio_out[3]` is high for exactly one cycle after each UPDATE.
- Segment and enable outputs are registered. They change together, in the cycle after the prescaler wraps, so there is no ghosting glitch.
- Reset asserted mid-conversion returns everything to reset values immediately, with no partial update.
- `ena` low freezes every register, including the prescaler.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: in decimal mode, d2 is blanked when the value is < 100, and d1 is blanked when the value is < 10. d0 is never blanked. Hex mode is unaffected.
  - Undefined: all three decimal digits are always shown, e.g. "007".

## Test plan
- Reset, then `ui_in` = 0 in decimal mode: `uo_out` = 3F on all digits (blanking undefined). With `LEADING_ZERO_BLANK_EN`, digits 2 and 1 show 00.
- `ui_in` = 255, mode dec, REFRESH_DIV = 4: the strobe fires 10 cycles after capture; the digit 2/1/0 segments are 5B/6D/6D.
- `ui_in` = 8'hA7, mode hex: digit 2 = 77, digit 1 = 07, digit 0 = 80 (dp only).
- `ui_in` changes from 42 to 99 three cycles into SHIFT: the next update shows 042, and the following update shows 099.
- Hold = 1 at cycle 4 of SHIFT: one more strobe occurs, then no strobes while held; the display keeps the last value.
- `rst_n` pulsed low during SHIFT with `ui_in` = 200: outputs immediately return to 3F/01; no strobe occurs.
